// File: rtl/sp_link_sync_ctrl.sv
// Receive word aligner: sliding-window comma search, lock after LOCK_BC aligned commas, resync after ERR_LIMIT bad idle bytes.
// Optional build macro SP_SYNC_STATS_EN adds resync_count and slip_seen.
module sp_link_sync_ctrl #(
  parameter logic [7:0]  COMMA     = 8'hBC,
  parameter int unsigned LOCK_BC   = 4,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       rx_bit,
  input  logic       rx_valid,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic [2:0] word_phase,
  output logic [1:0] sync_state,
  output logic [3:0] bc_count
`ifdef SP_SYNC_STATS_EN
  ,
  output logic [7:0] resync_count,
  output logic       slip_seen
`endif
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ALIGNED = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N = LOCK_BC[3:0];
  localparam logic [3:0] ERR_N  = ERR_LIMIT[3:0];

  state_t     state_q, state_d;
  logic [6:0] shreg_q, shreg_d;
  logic [2:0] phase_q, phase_d;
  logic [3:0] bc_q, bc_d;
  logic [3:0] err_q, err_d;
  logic [7:0] dout_q, dout_d;
  logic       vout_q, vout_d;

  logic [7:0] win;
  logic       boundary;
  logic       is_comma;

  // win is the byte ending on the bit arriving this cycle
  assign win      = {shreg_q, rx_bit};
  assign boundary = (phase_q == 3'd7);
  assign is_comma = (win == COMMA);

  always_ff @(posedge clk_32f) begin
    if (!reset) state_q <= ST_SEARCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEARCH: begin
        if (is_comma) state_d = (LOCK_N == 4'd1) ? ST_LOCKED : ST_ALIGNED;
      end
      ST_ALIGNED: begin
        if (boundary) begin
          if (!is_comma)                    state_d = ST_SEARCH;
          else if (bc_q + 4'd1 == LOCK_N)   state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (boundary && !is_comma && !rx_valid && (err_q + 4'd1 == ERR_N)) state_d = ST_SEARCH;
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_comb begin
    active     = (state_q == ST_LOCKED);
    sync_state = state_q;
  end

  always_comb begin
    shreg_d = win[6:0];
    phase_d = phase_q + 3'd1;
    bc_d    = bc_q;
    err_d   = err_q;
    dout_d  = dout_q;
    vout_d  = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        // an acquired comma defines a new boundary here, so the next bit is phase 0
        if (is_comma) begin
          phase_d = 3'd0;
          bc_d    = 4'd1;
        end
      end
      ST_ALIGNED: begin
        if (boundary) bc_d = is_comma ? bc_q + 4'd1 : 4'd0;
      end
      ST_LOCKED: begin
        vout_d = vout_q;
        if (boundary) begin
          if (is_comma) begin
            vout_d = 1'b0;
            err_d  = 4'd0;
          end else if (rx_valid) begin
            dout_d = win;
            vout_d = 1'b1;
          end else begin
            vout_d = 1'b0;
            err_d  = err_q + 4'd1;
            if (err_d == ERR_N) begin
              err_d = 4'd0;
              bc_d  = 4'd0;
            end
          end
        end
      end
      default: bc_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      shreg_q <= '0;
      phase_q <= '0;
      bc_q    <= '0;
      err_q   <= '0;
      dout_q  <= 8'h00;
      vout_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      phase_q <= phase_d;
      bc_q    <= bc_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
    end
  end

  assign data_out   = dout_q;
  assign valid_out  = vout_q;
  assign word_phase = phase_q;
  assign bc_count   = bc_q;

`ifdef SP_SYNC_STATS_EN
  logic [7:0] resync_q, resync_d;
  logic       slip_q, slip_d;

  always_comb begin
    resync_d = resync_q;
    if (state_q == ST_LOCKED && state_d == ST_SEARCH && resync_q != 8'hFF) resync_d = resync_q + 8'd1;
    // the old framing put boundaries at phase 7; acquiring anywhere else is a slip
    slip_d = (state_q == ST_SEARCH) && is_comma && !boundary;
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      resync_q <= 8'h00;
      slip_q   <= 1'b0;
    end else begin
      resync_q <= resync_d;
      slip_q   <= slip_d;
    end
  end

  assign resync_count = resync_q;
  assign slip_seen    = slip_q;
`endif

endmodule
